// File: rtl/eth_frame_fifo_if.sv
// eth_frame_fifo_if: write-side and read-side stream signals of the Ethernet
// receive frame FIFO.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where valid && ready. The source holds data/last/err stable while
// valid && !ready. wr_ready is tied high by the FIFO. Frames that do not fit
// are dropped rather than stalled.
//
// Modports:
//   slave  - the FIFO's view: consumes wr_* and rd_ready, drives wr_ready and rd_*
//   master - the environment's view: the MAC side plus the downstream consumer
interface eth_frame_fifo_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_err;
  logic                  wr_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_ready;

  modport slave (
    input  wr_valid, wr_data, wr_last, wr_err, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );

  modport master (
    output wr_valid, wr_data, wr_last, wr_err, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/eth_frame_fifo.sv
// eth_frame_fifo: single-clock store-and-forward frame FIFO for the Ethernet
// receive path. Write beats are stored speculatively and become readable only
// when the frame's last beat arrives without an error. Errored frames and
// frames that run out of space are rolled back and never reach the read side.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   bus          - eth_frame_fifo_if.slave (write stream in, read stream out)
//   level        - words stored, speculative included, output register excluded
//   almost_full  - free space <= AFULL_MARGIN
//   frame_count  - committed frames not yet fully read
//   drop_count   - frames discarded (saturating)
//   overflow     - one-cycle pulse when a frame is dropped for lack of space
//   dropping     - write FSM state (1 = discarding the rest of a frame)
module eth_frame_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_MARGIN = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_frame_fifo_if.slave       bus,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  overflow,
  output logic                  dropping
);
  localparam int                    DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic                  AF_RST  = (AFULL_MARGIN >= DEPTH);

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } state_t;

  state_t state;

  // Each entry carries the last flag alongside the payload.
  logic [DATA_WIDTH:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt, commit_ptr_nxt, rd_ptr_nxt;
  logic [ADDR_WIDTH:0] level_nxt, free_nxt;
  logic                wr_en, commit, drop_evt, ovf_evt;
  logic                fetch, rd_last_fire;

  assign bus.wr_ready = 1'b1;
  assign dropping     = (state == ST_DROP);

  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    wr_en          = 1'b0;
    commit         = 1'b0;
    drop_evt       = 1'b0;
    ovf_evt        = 1'b0;
    if (state == ST_ACCEPT && bus.wr_valid) begin
      // level is the registered wr_ptr - rd_ptr, so space freed by a fetch
      // this cycle only becomes usable next cycle.
      if (level < DEPTH_L) begin
        wr_en      = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (bus.wr_last) begin
          if (!bus.wr_err) begin
            commit         = 1'b1;
            commit_ptr_nxt = wr_ptr + PTR_ONE;
          end else begin
            wr_ptr_nxt = commit_ptr;
            drop_evt   = 1'b1;
          end
        end
      end else begin
        wr_ptr_nxt = commit_ptr;
        drop_evt   = 1'b1;
        ovf_evt    = 1'b1;
      end
    end

    // Fetch looks at the pre-edge commit_ptr, giving one cycle commit-to-valid.
    fetch        = (rd_ptr != commit_ptr) && (!bus.rd_valid || bus.rd_ready);
    rd_ptr_nxt   = fetch ? rd_ptr + PTR_ONE : rd_ptr;
    rd_last_fire = bus.rd_valid && bus.rd_ready && bus.rd_last;

    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    free_nxt  = DEPTH_L - level_nxt;
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ACCEPT;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_last  <= 1'b0;
      level        <= '0;
      almost_full  <= AF_RST;
      frame_count  <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      commit_ptr  <= commit_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      level       <= level_nxt;
      almost_full <= (32'(free_nxt) <= AFULL_MARGIN);
      overflow    <= ovf_evt;

      case (state)
        ST_ACCEPT: if (ovf_evt && !bus.wr_last) state <= ST_DROP;
        ST_DROP:   if (bus.wr_valid && bus.wr_last) state <= ST_ACCEPT;
        default:   state <= ST_ACCEPT;
      endcase

      if (fetch) begin
        bus.rd_valid                <= 1'b1;
        {bus.rd_last, bus.rd_data}  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else if (bus.rd_ready) begin
        bus.rd_valid <= 1'b0;
      end

      // A commit and a last-beat read in the same cycle cancel out.
      if (commit && !rd_last_fire)      frame_count <= frame_count + CNT_ONE;
      else if (!commit && rd_last_fire) frame_count <= frame_count - CNT_ONE;

      if (drop_evt && drop_count != '1) drop_count <= drop_count + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_eth_frame_fifo.sv
// Bench for eth_frame_fifo: directed scenarios plus randomized frames, checked
// every cycle against a queue-based model of committed and speculative beats.
module tb_eth_frame_fifo;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 1 << AW;
  localparam int MARGIN = 4;
  localparam int CW     = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_frame_fifo_if #(.DATA_WIDTH(DW)) bus ();
  logic [AW:0]   level;
  logic          almost_full;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic          overflow;
  logic          dropping;

  eth_frame_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_MARGIN(MARGIN), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .level(level), .almost_full(almost_full), .frame_count(frame_count),
    .drop_count(drop_count), .overflow(overflow), .dropping(dropping)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [DW:0] exp_q[$];   // committed beats not yet in the output register
  logic [DW:0] spec_q[$];  // beats of the frame currently being written
  logic        m_rv;
  logic [DW:0] m_out;
  logic        m_drop;
  int          m_fc;
  int          m_dc;
  logic        m_ovf;

  int rd_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
  int tick    = 0;
  int ovf_pulses;
  int last_reads;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    spec_q.delete();
    m_rv   = 1'b0;
    m_out  = '0;
    m_drop = 1'b0;
    m_fc   = 0;
    m_dc   = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the reference: read side first (it sees only beats
  // committed before this edge), then the write side.
  task automatic model_step();
    int occ;
    bit do_fetch;
    occ   = exp_q.size() + spec_q.size();
    m_ovf = 1'b0;
    if (m_rv && bus.rd_ready && m_out[DW]) m_fc--;
    do_fetch = (exp_q.size() > 0) && (!m_rv || bus.rd_ready);
    if (do_fetch) begin
      m_out = exp_q.pop_front();
      m_rv  = 1'b1;
    end else if (bus.rd_ready) begin
      m_rv = 1'b0;
    end
    if (bus.wr_valid) begin
      if (m_drop) begin
        if (bus.wr_last) m_drop = 1'b0;
      end else if (occ < DEPTH) begin
        spec_q.push_back({bus.wr_last, bus.wr_data});
        if (bus.wr_last) begin
          if (!bus.wr_err) begin
            for (int i = 0; i < spec_q.size(); i++) exp_q.push_back(spec_q[i]);
            m_fc++;
          end else if (m_dc < 65535) begin
            m_dc++;
          end
          spec_q.delete();
        end
      end else begin
        spec_q.delete();
        m_ovf = 1'b1;
        if (m_dc < 65535) m_dc++;
        if (!bus.wr_last) m_drop = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = exp_q.size() + spec_q.size();
    check("wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    if (m_rv) begin
      check("rd_data", 32'(bus.rd_data), 32'(m_out[DW-1:0]));
      check("rd_last", 32'(bus.rd_last), 32'(m_out[DW]));
    end
    check("level", 32'(level), 32'(lvl));
    check("almost_full", 32'(almost_full), 32'((DEPTH - lvl) <= MARGIN));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("drop_count", 32'(drop_count), 32'(m_dc));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("dropping", 32'(dropping), 32'(m_drop));
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic pick_ready();
    case (rd_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return tick[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic beat(input logic v, input logic [DW-1:0] d, input logic l, input logic e);
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.wr_last  = l;
    bus.wr_err   = e;
    bus.rd_ready = pick_ready();
    tick++;
    if (bus.rd_valid && bus.rd_ready && bus.rd_last) last_reads++;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (overflow) ovf_pulses++;
  endtask

  task automatic frame(input int len, input logic err, input int base);
    for (int i = 0; i < len; i++)
      beat(1'b1, DW'(base + i), (i == len - 1), err && (i == len - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic rand_frame();
    int len;
    logic err;
    int i;
    len = $urandom_range(1, 20);
    err = ($urandom_range(0, 7) == 0);
    i   = 0;
    while (i < len) begin
      if ($urandom_range(0, 3) == 0) begin
        beat(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        beat(1'b1, DW'($urandom), (i == len - 1), err && (i == len - 1));
        i++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.wr_err   = 1'b0;
    bus.rd_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;

    // Good frame, consumer always ready
    rd_mode = 1;
    frame(4, 1'b0, 'h11);
    idle(6);

    // Errored frame followed by a good one
    frame(3, 1'b1, 'h30);
    frame(2, 1'b0, 'hA0);
    idle(5);
    check("bad_drop_count", 32'(drop_count), 32'd1);
    check("bad_level", 32'(level), 32'd0);

    // Overflow: second frame runs out of space while the reader is stalled
    rd_mode    = 0;
    ovf_pulses = 0;
    frame(10, 1'b0, 'h40);
    frame(10, 1'b0, 'h60);
    idle(2);
    check("ovf_pulses", 32'(ovf_pulses), 32'd1);
    check("ovf_level", 32'(level), 32'd9);
    check("ovf_frames", 32'(frame_count), 32'd1);
    check("ovf_drops", 32'(drop_count), 32'd2);
    rd_mode = 1;
    idle(15);

    // Backpressure: alternate ready while three frames stream through
    rd_mode    = 2;
    last_reads = 0;
    frame(3, 1'b0, 'h80);
    frame(4, 1'b0, 'h88);
    frame(2, 1'b0, 'h90);
    idle(24);
    check("bp_last_reads", 32'(last_reads), 32'd3);

    // Commit lands on the same edge as the previous frame's last read
    rd_mode = 1;
    idle(4);
    frame(2, 1'b0, 'hC0);
    frame(3, 1'b0, 'hD0);
    check("simul_frames", 32'(frame_count), 32'd1);
    idle(8);

    // almost_full threshold
    rd_mode = 0;
    for (int i = 0; i < 11; i++) beat(1'b1, DW'(i), 1'b0, 1'b0);
    check("af_below", 32'(almost_full), 32'd0);
    beat(1'b1, DW'(11), 1'b0, 1'b0);
    check("af_at", 32'(almost_full), 32'd1);
    check("af_level", 32'(level), 32'(DEPTH - MARGIN));
    beat(1'b1, DW'(12), 1'b1, 1'b0);
    rd_mode = 1;
    idle(20);

    // Asynchronous reset mid-frame with a beat in the output register
    rd_mode = 0;
    frame(3, 1'b0, 'hE0);
    frame(2, 1'b0, 'hE8);  // partial: no last yet is not possible here, so
    beat(1'b1, DW'('hEF), 1'b0, 1'b0);
    beat(1'b1, DW'('hF0), 1'b0, 1'b0);
    check("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
    bus.wr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("arst_rd_data", 32'(bus.rd_data), 32'd0);
    check("arst_rd_last", 32'(bus.rd_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_mode = 1;
    frame(4, 1'b0, 'hF4);
    idle(8);

    // Randomized frames and consumer
    rd_mode = 3;
    for (int f = 0; f < 150; f++) begin
      rand_frame();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rd_mode = 1;
    idle(40);
    check("drain_level", 32'(level), 32'd0);
    check("drain_frames", 32'(frame_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
